// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder
//   Receiving end of a toggle-encoded event link. A remote T flip-flop flips its
//   output once per event. This block synchronizes that level and turns each
//   flip into a one-cycle pulse. It holds the event as a valid/ready request and
//   keeps counts of decoded and dropped events.
//
//   Optional feature: define TOGGLE_DEC_FILTER_EN to enable the glitch filter.
//   With the filter, the synchronized level must match its previous sample
//   before it is accepted. This rejects one-cycle glitches and adds one cycle of
//   latency. Without the macro, every change of tog_level is decoded directly.
//
//   rst_n is asserted asynchronously. Its release is expected to arrive already
//   synchronized to clk.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   tog_in      in   toggle level from the remote T-FF (asynchronous to clk)
//   tog_level   out  synchronized copy of tog_in
//   evt_pulse   out  one-cycle pulse per decoded flip
//   evt_valid   out  event pending for the consumer
//   evt_ready   in   consumer accepts the pending event
//   evt_count   out  decoded flips since reset (wraps)
//   drop_count  out  flips lost while an event was pending (saturates)
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tog_in,
    output logic             tog_level,
    output logic             evt_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_count,
    output logic [CNT_W-1:0] drop_count
);

    typedef enum logic [1:0] {ARM, IDLE, PEND} state_t;

    localparam int ARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

    state_t             state_q, state_d;
    logic [ARM_W-1:0]   arm_q, arm_d;
    logic               prev_q, prev_d;
    logic               pulse_q, pulse_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               cand;
    logic               edge_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
    end

    assign tog_level = sync_q[SYNC_STAGES-1];

`ifdef TOGGLE_DEC_FILTER_EN
    // A new level is accepted only after two equal consecutive samples.
    // Until then, the last accepted level is kept, so no edge is seen.
    logic lvl_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvl_q <= 1'b0;
        else        lvl_q <= tog_level;
    end
    assign cand = (tog_level == lvl_q) ? tog_level : prev_q;
`else
    assign cand = tog_level;
`endif

    assign edge_det = (state_q != ARM) && (cand != prev_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARM;
            arm_q   <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // ARM lasts until the reset zeros have flushed out of the synchronizer.
    // This way, a level that is already high at reset release is taken as the
    // baseline and is not decoded as an event.
    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        prev_d  = cand;
        pulse_d = edge_det;
        cnt_d   = edge_det ? cnt_q + 1'b1 : cnt_q;
        drop_d  = drop_q;
        case (state_q)
            ARM: begin
                prev_d = tog_level;
                if (arm_q == ARM_LAST) state_d = IDLE;
                else                   arm_d   = arm_q + 1'b1;
            end
            IDLE: begin
                if (edge_det) state_d = PEND;
            end
            PEND: begin
                // A new flip while the old event is unaccepted is lost.
                // A flip in the same cycle as acceptance replaces the old event.
                if (edge_det) begin
                    if (!evt_ready && (drop_q != '1)) drop_d = drop_q + 1'b1;
                end else if (evt_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = ARM;
        endcase
    end

    assign evt_pulse  = pulse_q;
    assign evt_valid  = (state_q == PEND);
    assign evt_count  = cnt_q;
    assign drop_count = drop_q;

endmodule
